// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter that merges several valid/ready streams into one registered output,
// keeping multi-beat packets together by locking onto a requester until its last beat.
module rr_stream_arbiter #(
   parameter int DataWidth = 32,
   parameter int NumInputs = 4,
   localparam int SelWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumInputs-1:0]           req_valid_i,
   input  logic [NumInputs-1:0]           req_last_i,
   input  logic [DataWidth*NumInputs-1:0] req_data_i,
   output logic [NumInputs-1:0]           req_ready_o,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [DataWidth-1:0]           out_data_o,
   output logic                           out_last_o,
   output logic [SelWidth-1:0]            out_sel_o
);

   typedef enum logic {ARB, LOCKED} state_e;

   state_e              state;
   logic [SelWidth-1:0] rr_ptr;
   logic [SelWidth-1:0] lock_idx;
   logic [SelWidth-1:0] arb_idx;
   logic [SelWidth-1:0] grant_idx;
   logic [SelWidth-1:0] next_ptr;
   logic                arb_found;
   logic                grant_valid;
   logic                can_load;
   logic                accept;
   logic                sel_last;
   logic [DataWidth-1:0] sel_data;

   assign can_load = !out_valid_o || out_ready_i;

   // Rotating priority in two passes: indices from rr_ptr upward, then wrap to the low indices.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int k = 0; k < NumInputs; k++) begin
         if (!arb_found && req_valid_i[k] && (SelWidth'(k) >= rr_ptr)) begin
            arb_found = 1'b1;
            arb_idx   = SelWidth'(k);
         end
      end
      for (int k = 0; k < NumInputs; k++) begin
         if (!arb_found && req_valid_i[k]) begin
            arb_found = 1'b1;
            arb_idx   = SelWidth'(k);
         end
      end
   end

   always_comb begin
      grant_valid = (state == LOCKED) ? 1'b1 : arb_found;
      grant_idx   = (state == LOCKED) ? lock_idx : arb_idx;
   end

   // Grant-indexed multiplexer; ready is only ever raised on the granted requester.
   always_comb begin
      sel_data    = '0;
      sel_last    = 1'b0;
      req_ready_o = '0;
      for (int k = 0; k < NumInputs; k++) begin
         if (grant_idx == SelWidth'(k)) begin
            sel_data       = req_data_i[k*DataWidth +: DataWidth];
            sel_last       = req_last_i[k];
            req_ready_o[k] = grant_valid && can_load && !rst_i;
         end
      end
   end

   assign accept   = |(req_valid_i & req_ready_o);
   assign next_ptr = (grant_idx == SelWidth'(NumInputs - 1)) ? '0 : grant_idx + SelWidth'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ARB;
         rr_ptr      <= '0;
         lock_idx    <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         out_sel_o   <= '0;
      end else begin
         if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= sel_data;
            out_last_o  <= sel_last;
            out_sel_o   <= grant_idx;
            case (state)
               ARB: begin
                  if (sel_last) begin
                     rr_ptr <= next_ptr;
                  end else begin
                     state    <= LOCKED;
                     lock_idx <= grant_idx;
                  end
               end
               LOCKED: begin
                  if (sel_last) begin
                     state  <= ARB;
                     rr_ptr <= next_ptr;
                  end
               end
               default: state <= ARB;
            endcase
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

endmodule
